// File: rtl/cpld_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpld_spi_responder
// Purpose  : SPI mode-0 responder giving an external SPI master (DSP or CPU)
//            read access to an ID byte and live board status, and read/write
//            access to a control register and a scratch register.
//            Frame: 16 bits MSB first = {R/W(1=read), addr[6:0], wdata[7:0]}.
//            All logic runs on sysclk; the SPI pins are oversampled.
// Ports    : sysclk         - system clock, rising edge
//            reset_INV      - synchronous active-low reset
//            spi_clk        - host SCLK (asynchronous)
//            spi_mosi       - host data (asynchronous)
//            spi_cs_INV     - host chip select, active low (asynchronous)
//            spi_miso       - responder data, registered
//            status_in[7:0] - live status, register 0x01
//            ctrl_out[7:0]  - control register 0x02
//            ctrl_wr_strobe - one-cycle pulse when ctrl_out is written
//            busy           - frame in progress (SHIFT state)
// Revision : 1.0 - initial release
// ============================================================================
module cpld_spi_responder #(
    parameter logic [7:0] ID_VALUE   = 8'hA5,
    parameter logic [7:0] CTRL_RESET = 8'h00
) (
    input  logic       sysclk,
    input  logic       reset_INV,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_INV,
    output logic       spi_miso,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic       ctrl_wr_strobe,
    output logic       busy
);

    localparam logic [1:0] c_WAIT_CS = 2'd0;
    localparam logic [1:0] c_IDLE    = 2'd1;
    localparam logic [1:0] c_SHIFT   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    // Synchronisers (s1, s2) plus one delay stage for edge detection.
    logic       r_sck_s1, r_sck_s2, r_sck_d;
    logic       r_mosi_s1, r_mosi_s2;
    logic       r_cs_s1, r_cs_s2, r_cs_d;

    logic [1:0] r_state;
    logic [4:0] r_bit_cnt;
    logic [14:0] r_shift_in;
    logic [7:0] r_shift_out;
    logic       r_miso;
    logic [7:0] r_ctrl;
    logic [7:0] r_scratch;
    logic       r_ctrl_wr_strobe;
    // Counts the cycles after reset until the CS synchroniser holds a real
    // pin sample rather than its reset value.
    logic [1:0] r_flush;

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_cs_fall;
    logic [7:0] w_addr_byte;
    logic [15:0] w_frame;
    logic [7:0] w_read_data;

    assign w_sck_rise = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s2 & r_sck_d;
    assign w_cs_fall  = ~r_cs_s2 & r_cs_d;

    // Header byte and whole frame as they stand once the bit being shifted
    // in on this sck_rise is included.
    assign w_addr_byte = {r_shift_in[6:0], r_mosi_s2};
    assign w_frame     = {r_shift_in, r_mosi_s2};

    // status_in is read live here; it is frozen by being loaded into the
    // output shift register at address-complete.
    always_comb begin
        w_read_data = 8'h00;
        case (w_addr_byte[6:0])
            7'h00:   w_read_data = ID_VALUE;
            7'h01:   w_read_data = status_in;
            7'h02:   w_read_data = r_ctrl;
            7'h03:   w_read_data = r_scratch;
            default: w_read_data = 8'h00;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_INV) begin
            r_sck_s1         <= 1'b0;
            r_sck_s2         <= 1'b0;
            r_sck_d          <= 1'b0;
            r_mosi_s1        <= 1'b0;
            r_mosi_s2        <= 1'b0;
            r_cs_s1          <= 1'b1;
            r_cs_s2          <= 1'b1;
            r_cs_d           <= 1'b1;
            r_state          <= c_WAIT_CS;
            r_bit_cnt        <= 5'd0;
            r_shift_in       <= 15'd0;
            r_shift_out      <= 8'h00;
            r_miso           <= 1'b0;
            r_ctrl           <= CTRL_RESET;
            r_scratch        <= 8'h00;
            r_ctrl_wr_strobe <= 1'b0;
            r_flush          <= 2'd0;
        end else begin
            r_sck_s1  <= spi_clk;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_mosi_s1 <= spi_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_cs_s1   <= spi_cs_INV;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;

            if (!r_flush[1]) begin
                r_flush <= r_flush + 2'd1;
            end

            r_ctrl_wr_strobe <= 1'b0;

            case (r_state)
                c_WAIT_CS: begin
                    // Only trust CS once the synchroniser has flushed out its
                    // reset value, so a frame live across reset is skipped.
                    r_miso <= 1'b0;
                    if (r_flush[1] && r_cs_s2) begin
                        r_state <= c_IDLE;
                    end
                end

                c_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_state     <= c_SHIFT;
                        r_bit_cnt   <= 5'd0;
                        r_shift_in  <= 15'd0;
                        r_shift_out <= 8'h00;
                    end
                end

                c_SHIFT: begin
                    if (w_sck_rise) begin
                        // SCLK edge wins over a simultaneous CS rise.
                        r_shift_in <= {r_shift_in[13:0], r_mosi_s2};
                        r_bit_cnt  <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            r_shift_out <= w_addr_byte[7] ? w_read_data : 8'h00;
                        end
                        if (r_bit_cnt == 5'd15) begin
                            if (!w_frame[15]) begin
                                if (w_frame[14:8] == 7'h02) begin
                                    r_ctrl           <= w_frame[7:0];
                                    r_ctrl_wr_strobe <= 1'b1;
                                end else if (w_frame[14:8] == 7'h03) begin
                                    r_scratch <= w_frame[7:0];
                                end
                            end
                            r_miso  <= 1'b0;
                            r_state <= r_cs_s2 ? c_IDLE : c_DONE;
                        end else if (r_cs_s2) begin
                            r_miso  <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end else if (r_cs_s2) begin
                        // Abort: CS released before the 16th bit.
                        r_miso  <= 1'b0;
                        r_state <= c_IDLE;
                    end else if (w_sck_fall) begin
                        if (r_bit_cnt >= 5'd8) begin
                            r_miso      <= r_shift_out[7];
                            r_shift_out <= {r_shift_out[6:0], 1'b0};
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end
                end

                c_DONE: begin
                    r_miso <= 1'b0;
                    if (r_cs_s2) begin
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_miso  <= 1'b0;
                    r_state <= c_WAIT_CS;
                end
            endcase
        end
    end

    assign spi_miso       = r_miso;
    assign ctrl_out       = r_ctrl;
    assign ctrl_wr_strobe = r_ctrl_wr_strobe;
    assign busy           = (r_state == c_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_cpld_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpld_spi_responder
// Purpose  : Directed self-checking bench for cpld_spi_responder. Acts as an
//            SPI mode-0 master with SCLK phases of HALF sysclk periods and
//            samples MISO on the SCLK rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpld_spi_responder;

    localparam int HALF = 6;

    logic       sysclk;
    logic       reset_INV;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_cs_INV;
    logic       spi_miso;
    logic [7:0] status_in;
    logic [7:0] ctrl_out;
    logic       ctrl_wr_strobe;
    logic       busy;

    int checks;
    int errors;
    int strobe_cnt;
    int strobe_run;
    int strobe_max_run;
    logic [7:0] ctrl_at_strobe;

    cpld_spi_responder #(
        .ID_VALUE   (8'hA5),
        .CTRL_RESET (8'h00)
    ) dut (
        .sysclk         (sysclk),
        .reset_INV      (reset_INV),
        .spi_clk        (spi_clk),
        .spi_mosi       (spi_mosi),
        .spi_cs_INV     (spi_cs_INV),
        .spi_miso       (spi_miso),
        .status_in      (status_in),
        .ctrl_out       (ctrl_out),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .busy           (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge sysclk) begin
        if (ctrl_wr_strobe === 1'b1) begin
            strobe_cnt     = strobe_cnt + 1;
            strobe_run     = strobe_run + 1;
            ctrl_at_strobe = ctrl_out;
            if (strobe_run > strobe_max_run) strobe_max_run = strobe_run;
        end else begin
            strobe_run = 0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic spi_start();
        spi_cs_INV = 1'b0;
        wait_cycles(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_cycles(HALF);
        spi_clk = 1'b1;
        m = spi_miso;
        wait_cycles(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic spi_end();
        wait_cycles(HALF);
        spi_cs_INV = 1'b1;
        spi_mosi   = 1'b0;
        wait_cycles(2 * HALF);
    endtask

    task automatic spi_frame(input logic [15:0] d, output logic [15:0] m);
        logic b;
        spi_start();
        for (int i = 0; i < 16; i++) begin
            spi_bit(d[15-i], b);
            m[15-i] = b;
        end
        spi_end();
    endtask

    task automatic test_reset();
        reset_INV  = 1'b0;
        spi_clk    = 1'b0;
        spi_mosi   = 1'b0;
        spi_cs_INV = 1'b1;
        status_in  = 8'h00;
        wait_cycles(4);
        reset_INV = 1'b1;
        wait_cycles(1);
        checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
        checks++; if (ctrl_out !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", ctrl_out); end
        checks++; if (ctrl_wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", ctrl_wr_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        wait_cycles(6);
    endtask

    task automatic test_read_id();
        logic [15:0] m;
        logic b;
        int s0;
        logic busy_mid;
        s0 = strobe_cnt;
        spi_start();
        busy_mid = busy;
        for (int i = 0; i < 16; i++) begin
            spi_bit((i == 0) ? 1'b1 : 1'b0, b);
            m[15-i] = b;
        end
        spi_end();
        checks++; if (m !== 16'h00A5) begin errors++; $display("FAIL read_id: got %h expected 00a5", m); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL read_id_strobe: got %0d expected 0", strobe_cnt - s0); end
        checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL busy_in_frame: got %b expected 1", busy_mid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_frame: got %b expected 0", busy); end
    endtask

    task automatic test_write_ctrl();
        logic [15:0] m;
        int s0;
        s0 = strobe_cnt;
        strobe_max_run = 0;
        spi_frame(16'h0237, m);
        checks++; if (ctrl_out !== 8'h37) begin errors++; $display("FAIL write_ctrl: got %h expected 37", ctrl_out); end
        checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL write_strobe_cycles: got %0d expected 1", strobe_cnt - s0); end
        checks++; if (strobe_max_run != 1) begin errors++; $display("FAIL write_strobe_width: got %0d expected 1", strobe_max_run); end
        checks++; if (ctrl_at_strobe !== 8'h37) begin errors++; $display("FAIL ctrl_with_strobe: got %h expected 37", ctrl_at_strobe); end
        spi_frame(16'h8200, m);
        checks++; if (m !== 16'h0037) begin errors++; $display("FAIL read_ctrl: got %h expected 0037", m); end
    endtask

    task automatic test_status_snapshot();
        logic [15:0] m;
        logic [15:0] d;
        logic b;
        d = 16'h8100;
        status_in = 8'h5A;
        spi_start();
        for (int i = 0; i < 16; i++) begin
            spi_bit(d[15-i], b);
            m[15-i] = b;
            if (i == 7) status_in = 8'hFF;
        end
        spi_end();
        checks++; if (m !== 16'h005A) begin errors++; $display("FAIL status_snapshot: got %h expected 005a", m); end
    endtask

    task automatic test_abort();
        logic [15:0] m;
        logic [15:0] d;
        logic b;
        int s0;
        d = 16'h0255;
        s0 = strobe_cnt;
        spi_start();
        for (int i = 0; i < 10; i++) spi_bit(d[15-i], b);
        spi_end();
        checks++; if (ctrl_out !== 8'h37) begin errors++; $display("FAIL abort_ctrl: got %h expected 37", ctrl_out); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL abort_strobe: got %0d expected 0", strobe_cnt - s0); end
        spi_frame(16'h0211, m);
        checks++; if (ctrl_out !== 8'h11) begin errors++; $display("FAIL post_abort_write: got %h expected 11", ctrl_out); end
        spi_frame(16'h0342, m);
        spi_frame(16'h8300, m);
        checks++; if (m !== 16'h0042) begin errors++; $display("FAIL scratch_rw: got %h expected 0042", m); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] m;
        logic [15:0] d;
        logic b;
        logic busy_mid;
        int s0;
        d = 16'h02CC;
        spi_start();
        for (int i = 0; i < 5; i++) spi_bit(d[15-i], b);
        reset_INV = 1'b0;
        wait_cycles(3);
        reset_INV = 1'b1;
        wait_cycles(1);
        checks++; if (ctrl_out !== 8'h00) begin errors++; $display("FAIL midreset_ctrl: got %h expected 00", ctrl_out); end
        s0 = strobe_cnt;
        busy_mid = 1'b0;
        for (int i = 5; i < 16; i++) begin
            spi_bit(d[15-i], b);
            if (busy === 1'b1) busy_mid = 1'b1;
        end
        checks++; if (busy_mid !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy_mid); end
        spi_end();
        checks++; if (ctrl_out !== 8'h00) begin errors++; $display("FAIL midreset_nowrite: got %h expected 00", ctrl_out); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL midreset_strobe: got %0d expected 0", strobe_cnt - s0); end
        spi_frame(16'h8300, m);
        checks++; if (m !== 16'h0000) begin errors++; $display("FAIL midreset_scratch: got %h expected 0000", m); end
        spi_frame(16'h0299, m);
        checks++; if (ctrl_out !== 8'h99) begin errors++; $display("FAIL post_reset_write: got %h expected 99", ctrl_out); end
    endtask

    task automatic test_overclock_unmapped();
        logic [15:0] m;
        logic [15:0] d;
        logic [3:0] extra;
        logic b;
        int s0;
        s0 = strobe_cnt;
        d = 16'h03AA;
        spi_start();
        for (int i = 0; i < 20; i++) begin
            spi_bit((i < 16) ? d[15-i] : 1'b0, b);
            if (i >= 16) extra[19-i] = b;
        end
        spi_end();
        checks++; if (extra !== 4'b0000) begin errors++; $display("FAIL overclk_wr_miso: got %b expected 0000", extra); end
        checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL overclk_strobe: got %0d expected 0", strobe_cnt - s0); end
        spi_frame(16'h8300, m);
        checks++; if (m !== 16'h00AA) begin errors++; $display("FAIL overclk_scratch: got %h expected 00aa", m); end
        d = 16'h8000;
        spi_start();
        for (int i = 0; i < 20; i++) begin
            spi_bit((i < 16) ? d[15-i] : 1'b0, b);
            if (i < 16) m[15-i] = b;
            else extra[19-i] = b;
        end
        spi_end();
        checks++; if (m !== 16'h00A5) begin errors++; $display("FAIL overclk_rd_data: got %h expected 00a5", m); end
        checks++; if (extra !== 4'b0000) begin errors++; $display("FAIL overclk_rd_miso: got %b expected 0000", extra); end
        spi_frame(16'h7F55, m);
        checks++; if (ctrl_out !== 8'h99) begin errors++; $display("FAIL unmapped_ctrl: got %h expected 99", ctrl_out); end
        spi_frame(16'hFF00, m);
        checks++; if (m !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h expected 0000", m); end
        spi_frame(16'h8300, m);
        checks++; if (m !== 16'h00AA) begin errors++; $display("FAIL unmapped_scratch: got %h expected 00aa", m); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        strobe_cnt     = 0;
        strobe_run     = 0;
        strobe_max_run = 0;
        ctrl_at_strobe = 8'h00;
        test_reset();
        test_read_id();
        test_write_ctrl();
        test_status_snapshot();
        test_abort();
        test_reset_mid_frame();
        test_overclock_unmapped();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
